// File: rtl/hex_pair_entry_if.sv
// Switch/key inputs and two-digit display outputs of the hex pair entry block.
interface hex_pair_entry_if;
  logic [3:0] sw;
  logic       key_n;
  logic       clr;
  logic [3:0] num1;
  logic [3:0] num2;
  logic       next_sel;
  logic       full;
  logic       pair_valid;

  modport master (
    output sw, key_n, clr,
    input  num1, num2, next_sel, full, pair_valid
  );

  modport slave (
    input  sw, key_n, clr,
    output num1, num2, next_sel, full, pair_valid
  );
endinterface

// File: rtl/hex_pair_entry.sv
// Debounced pushbutton entry of two hex digits from slide switches.
// The key is synchronized, debounced, and each accepted press loads the next digit.
module hex_pair_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    rst,
  hex_pair_entry_if.slave         bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    FULL   = 2'd2
  } state_e;

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_c;

  state_e           state_q, state_d;
  logic [3:0]       num1_q, num1_d;
  logic [3:0]       num2_q, num2_d;
  logic             next_sel_q, next_sel_d;
  logic             full_q, full_d;
  logic             pair_valid_q, pair_valid_d;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_c  = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
      press_c  = ~s2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Digit sequencing; clr overrides a coincident press but leaves the debouncer alone.
  always_comb begin
    state_d      = state_q;
    num1_d       = num1_q;
    num2_d       = num2_q;
    pair_valid_d = 1'b0;
    if (bus.clr) begin
      state_d = WAIT_A;
      num1_d  = 4'h0;
      num2_d  = 4'h0;
    end else if (press_c) begin
      unique case (state_q)
        WAIT_A: begin
          num1_d  = bus.sw;
          state_d = WAIT_B;
        end
        WAIT_B: begin
          num2_d       = bus.sw;
          state_d      = FULL;
          pair_valid_d = 1'b1;
        end
        FULL: begin
          num1_d  = bus.sw;
          num2_d  = 4'h0;
          state_d = WAIT_B;
        end
        default: begin
          state_d = WAIT_A;
        end
      endcase
    end
    next_sel_d = (state_d == WAIT_B);
    full_d     = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      stable_q     <= 1'b1;
      cnt_q        <= '0;
      state_q      <= WAIT_A;
      num1_q       <= 4'h0;
      num2_q       <= 4'h0;
      next_sel_q   <= 1'b0;
      full_q       <= 1'b0;
      pair_valid_q <= 1'b0;
    end else begin
      s1_q         <= bus.key_n;
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      num1_q       <= num1_d;
      num2_q       <= num2_d;
      next_sel_q   <= next_sel_d;
      full_q       <= full_d;
      pair_valid_q <= pair_valid_d;
    end
  end

  assign bus.num1       = num1_q;
  assign bus.num2       = num2_q;
  assign bus.next_sel   = next_sel_q;
  assign bus.full       = full_q;
  assign bus.pair_valid = pair_valid_q;

endmodule

// File: doc/hex_pair_entry.md
HEX_PAIR_ENTRY -- requirements
Module: hex_pair_entry

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable-differing samples needed to accept a key level change; legal range 2 to 2^24.
- REQ-002: clk  input  1  single rising-edge clock for all state.
- REQ-003: rst  input  1  asynchronous, active-low reset.
- REQ-004: sw  input  4  hex digit from slide switches, sampled only on an accepted press.
- REQ-005: key_n  input  1  raw, asynchronous, bouncing pushbutton; 0 = pressed.
- REQ-006: clr  input  1  synchronous clear of entered digits, active-high.
- REQ-007: num1  output  4  first entered digit; feeds the registered two-digit hex display stage.
- REQ-008: num2  output  4  second entered digit; feeds the same display stage.
- REQ-009: next_sel  output  1  0 = next press loads num1; 1 = next press loads num2.
- REQ-010: full  output  1  level; both digits hold a completed pair.
- REQ-011: pair_valid  output  1  single-cycle pulse; a new pair has just completed.

Function
- REQ-012: key_n SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
- REQ-013: The debouncer SHALL hold a stable level and a counter of at least clog2(DEBOUNCE_CYCLES) bits.
- REQ-014: Each edge with s2 != stable and cnt < DEBOUNCE_CYCLES-1 SHALL increment cnt.
- REQ-015: Each edge with s2 == stable SHALL zero cnt, so glitches shorter than DEBOUNCE_CYCLES samples are discarded.
- REQ-016: An edge with s2 != stable and cnt == DEBOUNCE_CYCLES-1 SHALL set stable to s2 and zero cnt.
- REQ-017: A press event SHALL occur only on the edge where stable changes 1->0; a 0->1 change (release) SHALL produce no event.
- REQ-018: A held key SHALL produce exactly one event, with no auto-repeat.
- REQ-019: The FSM states SHALL be WAIT_A (next_sel=0, full=0), WAIT_B (next_sel=1, full=0) and FULL (next_sel=0, full=1).
- REQ-020: In WAIT_A, a press event SHALL load num1<=sw on that same edge and move to WAIT_B; num2 is unchanged.
- REQ-021: In WAIT_B, a press event SHALL load num2<=sw on that same edge and move to FULL.
- REQ-022: pair_valid SHALL be 1 for exactly the cycle following the WAIT_B->FULL edge.
- REQ-023: In FULL, a press event SHALL load num1<=sw, set num2<=0 and move to WAIT_B (wrap-around, no pair_valid).
- REQ-024: With no press event, the state and num1/num2 SHALL hold.
- REQ-025: clr=1 SHALL set num1=num2=0, state WAIT_A and pair_valid=0 on the next edge, from any state.
- REQ-026: clr SHALL leave the synchronizer and debouncer untouched.
- REQ-027: If clr and a press event coincide, clr SHALL win, the press SHALL be discarded, and stable SHALL still update.
- REQ-028: Load latency SHALL be 2+DEBOUNCE_CYCLES edges after the first edge that samples key_n=0, provided key_n stays 0 throughout.

Reset
- REQ-029: rst=0 SHALL immediately force num1=0, num2=0, state WAIT_A, next_sel=0, full=0, pair_valid=0, s1=s2=stable=1 and cnt=0, regardless of any operation in progress.
- REQ-030: After rst rises, a key still held SHALL be treated as a new press and accepted per REQ-028.

Verification (DEBOUNCE_CYCLES=4)
- REQ-031: sw=4'hA, key_n held low from edge 1 -> num1=A and next_sel=1 exactly at edge 6; num2=0; no second load while the key stays held.
- REQ-032: Press with sw=3, then press with sw=7 -> num1=3, num2=7, full=1, and pair_valid high for one cycle after the second load.
- REQ-033: From FULL with num1=3, num2=7, press with sw=5 -> num1=5, num2=0, next_sel=1, full=0, pair_valid stays 0.
- REQ-034: key_n low pulses of 1, 2 and 3 samples separated by high samples -> no load; then a 4-sample low -> exactly one load.
- REQ-035: clr asserted on the same edge as the press event in WAIT_B -> num1=num2=0, state WAIT_A, no pair_valid; releasing and re-pressing then loads num1.
- REQ-036: rst pulsed low mid-count (cnt=2) while key held -> all outputs reset immediately; after rst rises, the load occurs 6 edges later.
